// File: rtl/sys_in_byte.sv
// Memory-mapped inbound byte port on the picorv32 native bus: external pushes fill a
// small FIFO that the CPU polls via STATUS and drains via DATA loads.
module sys_in_byte #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned DEPTH     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        sel,
   input  logic [7:0]  in_byte,
   input  logic        in_byte_en
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [1:0] OFF_STATUS = 2'b01;
   localparam logic [1:0] OFF_DATA   = 2'b10;

   typedef enum logic {IDLE, RESP} state_e;

   state_e        state_q, state_d;
   logic          mem_ready_q, mem_ready_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    fifo_q [DEPTH];

   logic          accept, is_read, empty, full, pop, push_ok, clr;
   logic [1:0]    offset;
   logic [31:0]   count_ext, status_word;
   logic          unused;

   assign offset  = mem_addr[3:2];
   assign is_read = (mem_wstrb == 4'b0000);
   assign sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && (offset != 2'b00);

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

   assign count_ext   = 32'(count_q);
   assign status_word = {16'h0000, count_ext[7:0], 6'b000000, overflow_q, !empty};

   // Response handshake: one-cycle latency, ready held for exactly one cycle.
   always_comb begin
      state_d     = state_q;
      mem_ready_d = 1'b0;
      rdata_d     = '0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel && !mem_ready_q) begin
               accept      = 1'b1;
               mem_ready_d = 1'b1;
               state_d     = RESP;
               if (is_read) begin
                  case (offset)
                     OFF_STATUS: rdata_d = status_word;
                     OFF_DATA:   rdata_d = empty ? 32'h0 : {24'h0, fifo_q[rd_ptr_q]};
                     default:    rdata_d = '0;
                  endcase
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign pop     = accept && is_read && (offset == OFF_DATA) && !empty;
   assign clr     = accept && !is_read && (offset == OFF_STATUS) && mem_wstrb[0] && mem_wdata[1];
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
   assign push_ok = in_byte_en && (!full || pop);

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = (in_byte_en && full && !pop) || (overflow_q && !clr);
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_ready_q <= 1'b0;
         rdata_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_ready_q <= mem_ready_d;
         rdata_q     <= rdata_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

   // NOTE: storage has no reset; empty slots are never observable because reads gate on count.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= in_byte;
   end

   assign mem_ready = mem_ready_q;
   assign mem_rdata = rdata_q;

   assign unused = ^{mem_instr, mem_addr[1:0], mem_wdata[31:2], mem_wdata[0], count_ext[31:8]};

endmodule

// File: tb/tb_sys_in_byte.sv
// Scoreboard bench for sys_in_byte: a queue-based FIFO model predicts every bus response,
// and an independent monitor compares each mem_ready beat against the predictions.
module tb_sys_in_byte;

   localparam int          DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h1000_0000;

   logic        clk, reset;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        sel;
   logic [7:0]  in_byte;
   logic        in_byte_en;

   sys_in_byte #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_instr  (mem_instr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .sel        (sel),
      .in_byte    (in_byte),
      .in_byte_en (in_byte_en)
   );

   typedef struct {
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mq[$];
   logic       ovf;
   int         cyc;
   int         n_cmp, n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of FIFO behaviour, decided from the state before the edge.
   task automatic model_cycle(input logic push, input logic [7:0] b, input logic pop, input logic clr);
      bit was_full;
      bit set;
      was_full = (mq.size() == DEPTH);
      set      = 0;
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (!was_full || pop) mq.push_back(b);
         else set = 1;
      end
      if (set) ovf = 1'b1;
      else if (clr) ovf = 1'b0;
   endtask

   function automatic logic [31:0] model_status();
      logic [7:0] cnt;
      cnt = 8'(mq.size());
      return {16'h0000, cnt, 6'h00, ovf, (mq.size() != 0)};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (mem_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_ready: got mem_ready=1, expected no response (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check("rdata", mem_rdata, e.rdata);
               check("latency", cyc, e.cyc + 1);
            end
         end else begin
            check("rdata_idle", mem_rdata, 32'h0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      in_byte_en = 1'b1;
      in_byte    = b;
      model_cycle(1'b1, b, 1'b0, 1'b0);
      @(negedge clk);
      in_byte_en = 1'b0;
   endtask

   // Called on a falling edge; returns two falling edges later.
   task automatic access(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                         input logic push_en, input logic [7:0] pbyte, input logic instr, input bit hold);
      bit          hit, pop, clr;
      logic [31:0] exp;
      exp_t        e;
      mem_valid  = 1'b1;
      mem_instr  = instr;
      mem_addr   = addr;
      mem_wstrb  = wstrb;
      mem_wdata  = wdata;
      in_byte_en = push_en;
      in_byte    = pbyte;
      hit = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b00);
      pop = 0;
      clr = 0;
      exp = 32'h0;
      if (hit) begin
         if (wstrb == 4'b0000) begin
            if (addr[3:2] == 2'b01) exp = model_status();
            else if (addr[3:2] == 2'b10 && mq.size() != 0) begin
               exp = {24'h0, mq[0]};
               pop = 1;
            end
         end else if (addr[3:2] == 2'b01 && wstrb[0] && wdata[1]) begin
            clr = 1;
         end
         e.rdata = exp;
         e.cyc   = cyc;
         sb.push_back(e);
      end
      model_cycle(push_en, pbyte, pop, clr);
      #1 check("sel", {31'h0, sel}, {31'h0, hit});
      @(negedge clk);
      in_byte_en = 1'b0;
      if (!hold) mem_valid = 1'b0;
      @(negedge clk);
      mem_valid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] off);
      access(BASE + off, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, 0);
   endtask

   initial begin
      logic [31:0] offs [5];
      exp_t        e;
      offs = '{32'h4, 32'h8, 32'hC, 32'h0, 32'h10};
      n_cmp = 0; n_err = 0; cyc = 0; ovf = 1'b0;
      reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
      mem_wdata = '0; mem_wstrb = '0; in_byte = '0; in_byte_en = 1'b0;
      #2;
      check("reset_ready", {31'h0, mem_ready}, 32'h0);
      check("reset_rdata", mem_rdata, 32'h0);
      idle(2);
      reset = 1'b0;
      idle(1);

      // Reset asserted while a DATA response is on the bus
      push(8'h11); push(8'h22); push(8'h33);
      mem_valid = 1'b1; mem_addr = BASE + 32'h8; mem_wstrb = 4'h0;
      e.rdata = {24'h0, mq[0]}; e.cyc = cyc;
      sb.push_back(e);
      model_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("midresp_ready", {31'h0, mem_ready}, 32'h0);
      check("midresp_rdata", mem_rdata, 32'h0);
      mem_valid = 1'b0;
      mq.delete(); sb.delete(); ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      rd(32'h4);

      // Two bytes in order, then empty status
      push(8'h41); push(8'h42);
      rd(32'h8); rd(32'h8); rd(32'h4);

      // Overflow on the ninth byte, drain, clear by store
      for (int i = 0; i < 9; i++) push(8'(i));
      rd(32'h4);
      for (int i = 0; i < 8; i++) rd(32'h8);
      access(BASE + 32'h4, 4'h1, 32'h2, 1'b0, 8'h00, 1'b0, 0);
      rd(32'h4);

      // Full FIFO: pop and push in the same cycle
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      access(BASE + 32'h8, 4'h0, 32'h0, 1'b1, 8'hAA, 1'b0, 0);
      rd(32'h4);
      for (int i = 0; i < 8; i++) rd(32'h8);

      // Empty read, undecoded addresses, held request, acknowledged ignored writes
      rd(32'h8); rd(32'h4);
      access(BASE, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, 0);
      access(BASE + 32'h10, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, 0);
      access(BASE + 32'h4, 4'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1);
      access(BASE + 32'h8, 4'hF, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 0);
      rd(32'hC);

      // Overflow set and clear in the same cycle: set wins
      for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
      access(BASE + 32'h4, 4'h1, 32'h2, 1'b1, 8'hEE, 1'b0, 0);
      rd(32'h4);
      access(BASE + 32'h4, 4'h1, 32'h2, 1'b0, 8'h00, 1'b0, 0);
      for (int i = 0; i < 8; i++) rd(32'h8);

      // Pointer wrap with interleaved push/pop
      for (int i = 0; i < 20; i++) begin
         push(8'h30 + 8'(i));
         rd(32'h8);
      end
      access(BASE + 32'h10, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, 0);

      // Randomised mix
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            push(8'($urandom));
         end else begin
            logic [3:0] ws;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            access(BASE + offs[$urandom_range(0, 4)], ws, $urandom,
                   1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0));
         end
      end
      rd(32'h4);

      idle(3);
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
